// File: rtl/weight_wr_pkg.sv
// Shared types and constants for the weight write-path scheduler.
package weight_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    BURST,
    CLEAR,
    DONE
  } state_e;

  // Consecutive enabled '1' inputs a column needs for one weight increment.
  localparam int unsigned RUN_LEN     = 128;
  localparam int unsigned TIMEOUT_DEF = 130;

endpackage

// File: rtl/wsched_col_demux.sv
// Combinational column select: one-hot drive of col_en/col_din and the selected sp_col flag.
module wsched_col_demux #(
  parameter int unsigned NUM_COL = 8
) (
  input  logic [$clog2(NUM_COL)-1:0] col_i,
  input  logic                       drv_en_i,
  input  logic                       drv_one_i,
  input  logic [NUM_COL-1:0]         sp_col_i,
  output logic [NUM_COL-1:0]         col_en_o,
  output logic [NUM_COL-1:0]         col_din_o,
  output logic                       hit_o
);

  logic [NUM_COL-1:0] onehot;

  // An out-of-range column shifts the bit out, so nothing is driven and no hit is seen.
  always_comb begin
    onehot    = {{(NUM_COL-1){1'b0}}, 1'b1} << col_i;
    col_en_o  = onehot & {NUM_COL{drv_en_i}};
    col_din_o = onehot & {NUM_COL{drv_one_i}};
    hit_o     = |(sp_col_i & onehot);
  end

endmodule

// File: rtl/weight_wr_sched.sv
// Write-path scheduler: primes, bursts and clears one weight column per request.
// Optional abort input enabled by defining WEIGHT_WR_SCHED_ABORT_EN.
module weight_wr_sched
  import weight_wr_pkg::*;
#(
  parameter int unsigned NUM_COL = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       sys_clk,
  input  logic                       rst,
`ifdef WEIGHT_WR_SCHED_ABORT_EN
  input  logic                       abort,
`endif
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(NUM_COL)-1:0] req_col,
  input  logic [CNT_W-1:0]           req_inc,
  output logic [NUM_COL-1:0]         col_en,
  output logic [NUM_COL-1:0]         col_din,
  input  logic [NUM_COL-1:0]         sp_col_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [CNT_W-1:0]           done_cnt
);

  localparam int unsigned COL_W = $clog2(NUM_COL);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] inc_q, inc_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             eflag_q, eflag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hit, drv_en, drv_one, abort_req;

`ifdef WEIGHT_WR_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign drv_en  = (state_q == PRIME) || (state_q == BURST) || (state_q == CLEAR);
  assign drv_one = (state_q == BURST);

  wsched_col_demux #(
    .NUM_COL(NUM_COL)
  ) u_demux (
    .col_i    (col_q),
    .drv_en_i (drv_en),
    .drv_one_i(drv_one),
    .sp_col_i (sp_col_in),
    .col_en_o (col_en),
    .col_din_o(col_din),
    .hit_o    (hit)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    inc_d      = inc_q;
    hits_d     = hits_q;
    to_d       = to_q;
    eflag_d    = eflag_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    done_cnt_d = done_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          col_d      = req_col;
          inc_d      = req_inc;
          hits_d     = '0;
          to_d       = '0;
          eflag_d    = 1'b0;
          done_cnt_d = '0;
          state_d    = PRIME;
        end
      end
      PRIME: begin
        state_d = ((inc_q == '0) || abort_req) ? CLEAR : BURST;
      end
      BURST: begin
        if (hit) begin
          hits_d = hits_q + CNT_W'(1);
          to_d   = '0;
          if (hits_q == inc_q - CNT_W'(1)) state_d = CLEAR;
        end else if (to_q == TO_LAST) begin
          eflag_d = 1'b1;
          state_d = CLEAR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
        // An abort wins over a same-cycle timeout: it ends cleanly without err.
        if (abort_req) begin
          eflag_d = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        done_d     = 1'b1;
        err_d      = eflag_q;
        done_cnt_d = hits_q;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      inc_q      <= '0;
      hits_q     <= '0;
      to_q       <= '0;
      eflag_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      inc_q      <= inc_d;
      hits_q     <= hits_d;
      to_q       <= to_d;
      eflag_q    <= eflag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign done_cnt  = done_cnt_q;

endmodule
